// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM stage: one word-organised RAM access per request,
// answered WAIT_STATES+1 cycles after acceptance. Define DMEM_BYTE_EN for lane-masked stores.
module dmem_responder #(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_req,
  input  logic        mem_memWE,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
`ifdef DMEM_BYTE_EN
  input  logic [3:0]  mem_be,
`endif
  output logic        mem_stall,
  output logic [31:0] mem_rdata,
  output logic        mem_rvalid,
  output logic        mem_err
);

  localparam int unsigned CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                state;
  state_t                state_next;
  logic [CNT_W-1:0]      cnt;

  logic [ADDR_WIDTH-1:0] lat_word;
  logic                  lat_we;
  logic                  lat_mis;
  logic [31:0]           lat_wdata;
  logic [3:0]            lat_be;

  logic [31:0]           ram [DEPTH];

  logic [3:0]            in_be;
  logic                  in_mis;
  logic                  addr_unused;

  logic [ADDR_WIDTH-1:0] acc_word;
  logic                  acc_we;
  logic                  acc_mis;

`ifdef DMEM_BYTE_EN
  assign in_be       = mem_be;
  assign in_mis      = 1'b0;
  assign addr_unused = ^{mem_addr >> (ADDR_WIDTH + 2), mem_addr[1:0]};
`else
  assign in_be       = '1;
  assign in_mis      = (mem_addr[1:0] != 2'b00);
  assign addr_unused = ^(mem_addr >> (ADDR_WIDTH + 2));
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (mem_req) state_next = (WAIT_STATES > 0) ? WAIT : RESP;
      WAIT: if (cnt == CNT_W'(1)) state_next = RESP;
      RESP: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    mem_stall = mem_req & (state != RESP);
  end

  // Request capture and wait-state counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      lat_word  <= '0;
      lat_we    <= 1'b0;
      lat_mis   <= 1'b0;
      lat_wdata <= '0;
      lat_be    <= '0;
    end else begin
      if (state == IDLE && mem_req) begin
        cnt       <= CNT_W'(WAIT_STATES);
        lat_word  <= mem_addr[ADDR_WIDTH+1:2];
        lat_we    <= mem_memWE;
        lat_mis   <= in_mis;
        lat_wdata <= mem_wdata;
        lat_be    <= in_be;
      end else if (state == WAIT) begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

  // With zero wait states the edge into RESP is also the acceptance edge, so the
  // response path reads the live (stable, stalled) request instead of the latches.
  assign acc_word = (state == IDLE) ? mem_addr[ADDR_WIDTH+1:2] : lat_word;
  assign acc_we   = (state == IDLE) ? mem_memWE : lat_we;
  assign acc_mis  = (state == IDLE) ? in_mis : lat_mis;

  // Response registers are loaded on the edge into RESP so they are visible during RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_rdata  <= '0;
      mem_rvalid <= 1'b0;
      mem_err    <= 1'b0;
    end else begin
      mem_rvalid <= 1'b0;
      mem_err    <= 1'b0;
      if (state_next == RESP) begin
        mem_err <= acc_mis;
        if (!acc_we) begin
          mem_rvalid <= 1'b1;
          mem_rdata  <= acc_mis ? '0 : ram[acc_word];
        end
      end
    end
  end

  // Store commits on the edge leaving RESP; a reset forces IDLE so no write can occur.
  always_ff @(posedge clk) begin
    if (state == RESP && lat_we && !lat_mis) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (lat_be[i]) ram[lat_word][8*i +: 8] <= lat_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder: one instance with two wait states and
// one with zero wait states, sharing clock, reset and request fields.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        req0 = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  be = 4'hF;

  logic        stall, rvalid, err;
  logic [31:0] rdata;
  logic        stall0, rvalid0, err0;
  logic [31:0] rdata0;

  int total = 0;
  int bad = 0;
  logic [31:0] last_rd = '0;
  logic [31:0] last_rd0 = '0;

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(2)) dut (
    .clk(clk), .rst_n(rst_n), .mem_req(req), .mem_memWE(we),
    .mem_addr(addr), .mem_wdata(wdata),
`ifdef DMEM_BYTE_EN
    .mem_be(be),
`endif
    .mem_stall(stall), .mem_rdata(rdata), .mem_rvalid(rvalid), .mem_err(err)
  );

  dmem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .mem_req(req0), .mem_memWE(we),
    .mem_addr(addr), .mem_wdata(wdata),
`ifdef DMEM_BYTE_EN
    .mem_be(be),
`endif
    .mem_stall(stall0), .mem_rdata(rdata0), .mem_rvalid(rvalid0), .mem_err(err0)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input string what, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s.%s observed=%h expected=%h", tag, what, obs, exp);
    end
  endtask

  // One access on the two-wait-state instance: 3 stalled cycles, then the RESP cycle.
  task automatic acc(input string tag, input logic w, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] b, input logic exp_err,
                     input logic [31:0] exp_rd);
    req = 1'b1; we = w; addr = a; wdata = d; be = b;
    #1;
    chk(tag, "stall_accept", 32'(stall), 32'd1);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk(tag, "stall_wait", 32'(stall), 32'd1);
      chk(tag, "rvalid_wait", 32'(rvalid), 32'd0);
    end
    tick();
    if (!w) last_rd = exp_rd;
    chk(tag, "stall_resp", 32'(stall), 32'd0);
    chk(tag, "rvalid_resp", 32'(rvalid), 32'(!w));
    chk(tag, "err_resp", 32'(err), 32'(exp_err));
    chk(tag, "rdata_resp", rdata, last_rd);
    req = 1'b0;
    tick();
    chk(tag, "stall_after", 32'(stall), 32'd0);
    chk(tag, "rvalid_after", 32'(rvalid), 32'd0);
    chk(tag, "err_after", 32'(err), 32'd0);
    chk(tag, "rdata_hold", rdata, last_rd);
  endtask

  // One access on the zero-wait-state instance.
  task automatic acc0(input string tag, input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic [31:0] exp_rd);
    req0 = 1'b1; we = w; addr = a; wdata = d; be = 4'hF;
    #1;
    chk(tag, "stall_accept", 32'(stall0), 32'd1);
    tick();
    if (!w) last_rd0 = exp_rd;
    chk(tag, "stall_resp", 32'(stall0), 32'd0);
    chk(tag, "rvalid_resp", 32'(rvalid0), 32'(!w));
    chk(tag, "rdata_resp", rdata0, last_rd0);
    req0 = 1'b0;
    tick();
    chk(tag, "rvalid_after", 32'(rvalid0), 32'd0);
  endtask

  initial begin
    // Reset values
    tick();
    tick();
    chk("reset", "stall", 32'(stall), 32'd0);
    chk("reset", "rdata", rdata, 32'd0);
    chk("reset", "rvalid", 32'(rvalid), 32'd0);
    chk("reset", "err", 32'(err), 32'd0);
    rst_n = 1'b1;

    // No requests for 10 cycles
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle", "stall", 32'(stall), 32'd0);
      chk("idle", "rvalid", 32'(rvalid), 32'd0);
      chk("idle", "err", 32'(err), 32'd0);
    end

    // Store then load with two wait states
    acc("st10", 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0);
    acc("ld10", 1'b0, 32'h10, 32'h0, 4'hF, 1'b0, 32'hDEADBEEF);

    // Aliasing and misalignment
    acc("st00", 1'b1, 32'h0, 32'h01234567, 4'hF, 1'b0, 32'h0);
`ifdef DMEM_BYTE_EN
    acc("ld1002", 1'b0, 32'h1002, 32'h0, 4'hF, 1'b0, 32'h01234567);
`else
    acc("ld1002", 1'b0, 32'h1002, 32'h0, 4'hF, 1'b1, 32'h0);
`endif
    acc("ld1000", 1'b0, 32'h1000, 32'h0, 4'hF, 1'b0, 32'h01234567);
`ifdef DMEM_BYTE_EN
    acc("st11", 1'b1, 32'h11, 32'hFFFFFFFF, 4'hF, 1'b0, 32'h0);
    acc("ld10b", 1'b0, 32'h10, 32'h0, 4'hF, 1'b0, 32'hFFFFFFFF);
`else
    acc("st11", 1'b1, 32'h11, 32'hFFFFFFFF, 4'hF, 1'b1, 32'h0);
    acc("ld10b", 1'b0, 32'h10, 32'h0, 4'hF, 1'b0, 32'hDEADBEEF);
`endif

    // Zero wait states: preload, then back-to-back loads with req held
    acc0("z_st0", 1'b1, 32'h0, 32'hA5A50001, 32'h0);
    acc0("z_st4", 1'b1, 32'h4, 32'h5A5A0002, 32'h0);
    req0 = 1'b1; we = 1'b0; addr = 32'h0;
    #1;
    chk("b2b", "stall1", 32'(stall0), 32'd1);
    tick();
    chk("b2b", "stall2", 32'(stall0), 32'd0);
    chk("b2b", "rvalid2", 32'(rvalid0), 32'd1);
    chk("b2b", "rdata2", rdata0, 32'hA5A50001);
    addr = 32'h4;
    tick();
    chk("b2b", "stall3", 32'(stall0), 32'd1);
    chk("b2b", "rvalid3", 32'(rvalid0), 32'd0);
    tick();
    chk("b2b", "stall4", 32'(stall0), 32'd0);
    chk("b2b", "rvalid4", 32'(rvalid0), 32'd1);
    chk("b2b", "rdata4", rdata0, 32'h5A5A0002);
    req0 = 1'b0;
    tick();
    chk("b2b", "rvalid5", 32'(rvalid0), 32'd0);
    chk("b2b", "rdata_hold", rdata0, 32'h5A5A0002);

    // Reset during WAIT discards the pending store
    acc("st20", 1'b1, 32'h20, 32'hCAFEF00D, 4'hF, 1'b0, 32'h0);
    acc("ld20", 1'b0, 32'h20, 32'h0, 4'hF, 1'b0, 32'hCAFEF00D);
    req = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'h55555555;
    #1;
    tick();
    chk("rstmid", "stall_wait", 32'(stall), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rstmid", "rdata", rdata, 32'd0);
    chk("rstmid", "rvalid", 32'(rvalid), 32'd0);
    chk("rstmid", "err", 32'(err), 32'd0);
    chk("rstmid", "stall_req", 32'(stall), 32'd1);
    req = 1'b0;
    #1;
    chk("rstmid", "stall_noreq", 32'(stall), 32'd0);
    last_rd = '0;
    last_rd0 = '0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    acc("ld20r", 1'b0, 32'h20, 32'h0, 4'hF, 1'b0, 32'hCAFEF00D);

`ifdef DMEM_BYTE_EN
    // Byte-lane stores
    acc("be_full", 1'b1, 32'h8, 32'h11223344, 4'hF, 1'b0, 32'h0);
    acc("be_0010", 1'b1, 32'h8, 32'h0000AA00, 4'b0010, 1'b0, 32'h0);
    acc("be_ld", 1'b0, 32'h8, 32'h0, 4'hF, 1'b0, 32'h1122AA44);
    acc("be_none", 1'b1, 32'h8, 32'hFFFFFFFF, 4'b0000, 1'b0, 32'h0);
    acc("be_ld2", 1'b0, 32'h8, 32'h0, 4'hF, 1'b0, 32'h1122AA44);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
